// File: rtl/ibex_pmp_check_arbiter.sv
// Round-robin arbiter sharing one PMP check channel between NumReq requesters.
// A granted request is latched onto the channel, re-checked while PMP CSRs change, then answered with a one-cycle pulse.
module ibex_pmp_check_arbiter #(
    parameter int unsigned NumReq = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_valid_i,
    input  logic [NumReq-1:0][33:0]  req_addr_i,
    input  logic [NumReq-1:0][1:0]   req_type_i,
    input  logic [NumReq-1:0][1:0]   req_priv_i,
    output logic [NumReq-1:0]        req_ready_o,
    output logic [NumReq-1:0]        rsp_valid_o,
    output logic                     rsp_err_o,
    input  logic                     csr_pmp_update_i,
    output logic [33:0]              pmp_req_addr_o,
    output logic [1:0]               pmp_req_type_o,
    output logic [1:0]               pmp_priv_o,
    input  logic                     pmp_req_err_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    localparam logic [1:0] PMP_ACC_READ = 2'b10;
    localparam logic [1:0] PRIV_LVL_M   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_RESP  = 2'b10;

    localparam logic [NumReq-1:0] OneHotLsb = {{(NumReq-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [IdxW-1:0]   r_rr_ptr;
    logic [IdxW-1:0]   r_gnt_id;
    logic              r_err_q;
    logic [NumReq-1:0] r_rsp_valid;
    logic [33:0]       r_pmp_addr;
    logic [1:0]        r_pmp_type;
    logic [1:0]        r_pmp_priv;

    logic [NumReq-1:0] w_mask_hi;
    logic [NumReq-1:0] w_valid_hi;
    logic [NumReq-1:0] w_pick_vec;
    logic [IdxW-1:0]   w_gnt_idx;
    logic [IdxW-1:0]   w_rr_next;
    logic [NumReq-1:0] w_gnt_oh;
    logic [NumReq-1:0] w_gnt_id_oh;
    logic              w_can_grant;
    logic              w_accept;

    // Requesters at or above the round-robin pointer get priority on this pass.
    always_comb begin
        w_mask_hi = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_mask_hi[i] = (IdxW'(i) >= r_rr_ptr);
        end
    end

    assign w_valid_hi = req_valid_i & w_mask_hi;
    assign w_pick_vec = (|w_valid_hi) ? w_valid_hi : req_valid_i;

    // Lowest set bit of the selected vector gives the wrapped round-robin winner.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (w_pick_vec[i]) begin
                w_gnt_idx = IdxW'(i);
            end else begin
                w_gnt_idx = w_gnt_idx;
            end
        end
    end

    // Pointer advances past the winner, wrapping at NumReq (not a power of two in general).
    always_comb begin
        if (w_gnt_idx == IdxW'(NumReq - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_gnt_idx + IdxW'(1);
        end
    end

    assign w_can_grant = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !rst_i;
    assign w_accept    = w_can_grant && (|req_valid_i);
    assign w_gnt_oh    = OneHotLsb << w_gnt_idx;
    assign w_gnt_id_oh = OneHotLsb << r_gnt_id;

    assign req_ready_o    = w_accept ? w_gnt_oh : '0;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_err_o      = r_err_q;
    assign pmp_req_addr_o = r_pmp_addr;
    assign pmp_req_type_o = r_pmp_type;
    assign pmp_priv_o     = r_pmp_priv;

    // Main controller: accept, check (re-run while CSRs change), respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_err_q     <= 1'b0;
            r_rsp_valid <= '0;
            r_pmp_addr  <= 34'h0_0000_0000;
            r_pmp_type  <= PMP_ACC_READ;
            r_pmp_priv  <= PRIV_LVL_M;
        end else begin
            r_rsp_valid <= '0;
            r_err_q     <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_pmp_addr <= req_addr_i[w_gnt_idx];
                        r_pmp_type <= req_type_i[w_gnt_idx];
                        r_pmp_priv <= req_priv_i[w_gnt_idx];
                        r_gnt_id   <= w_gnt_idx;
                        r_rr_ptr   <= w_rr_next;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    // A CSR write invalidates this cycle's result; look again next cycle.
                    if (csr_pmp_update_i) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_err_q     <= pmp_req_err_i;
                        r_rsp_valid <= w_gnt_id_oh;
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_pmp_check_arbiter.sv
// Bench for ibex_pmp_check_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_ibex_pmp_check_arbiter;

    localparam int N = 3;

    localparam logic [1:0] ACC_EXEC  = 2'b00;
    localparam logic [1:0] ACC_WRITE = 2'b01;
    localparam logic [1:0] ACC_READ  = 2'b10;
    localparam logic [1:0] PRIV_U    = 2'b00;
    localparam logic [1:0] PRIV_S    = 2'b01;
    localparam logic [1:0] PRIV_M    = 2'b11;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][33:0]  req_addr = '0;
    logic [N-1:0][1:0]   req_type = '0;
    logic [N-1:0][1:0]   req_priv = '0;
    logic                csr_update = 1'b0;
    logic                tb_cfg = 1'b0;
    logic [N-1:0]        req_ready_o;
    logic [N-1:0]        rsp_valid_o;
    logic                rsp_err_o;
    logic [33:0]         pmp_req_addr_o;
    logic [1:0]          pmp_req_type_o;
    logic [1:0]          pmp_priv_o;
    logic                pmp_req_err_i;

    int n_cmp = 0;
    int n_err = 0;

    // Toy PMP channel: U-mode reads of 0x8xxx_xxxx are denied; the strict config denies all non-M accesses.
    function automatic logic pmp_deny(input logic [33:0] a, input logic [1:0] t, input logic [1:0] p, input logic cfg);
        return ((p == PRIV_U) && (a[31:28] == 4'h8) && (t == ACC_READ)) || (cfg && (p != PRIV_M));
    endfunction

    assign pmp_req_err_i = pmp_deny(pmp_req_addr_o, pmp_req_type_o, pmp_priv_o, tb_cfg);

    ibex_pmp_check_arbiter #(.NumReq(N)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid),
        .req_addr_i       (req_addr),
        .req_type_i       (req_type),
        .req_priv_i       (req_priv),
        .req_ready_o      (req_ready_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_err_o        (rsp_err_o),
        .csr_pmp_update_i (csr_update),
        .pmp_req_addr_o   (pmp_req_addr_o),
        .pmp_req_type_o   (pmp_req_type_o),
        .pmp_priv_o       (pmp_priv_o),
        .pmp_req_err_i    (pmp_req_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a check is either in flight or not; a finished check yields one response next cycle.
    logic         m_busy = 1'b0;
    logic         m_resp = 1'b0;
    int           m_gnt  = 0;
    int           m_rr   = 0;
    logic         m_err  = 1'b0;
    logic [33:0]  m_addr = '0;
    logic [1:0]   m_type = ACC_READ;
    logic [1:0]   m_priv = PRIV_M;

    function automatic int first_valid(input logic [N-1:0] v, input int rr);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (rr + k) % N;
            if (v[c[1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] idx_oh(input int g);
        logic [N-1:0] o;
        o = '0;
        if (g >= 0) o[g[1:0]] = 1'b1;
        return o;
    endfunction

    always @(posedge clk_i) begin : model
        int g;
        if (rst_i) begin
            m_busy = 1'b0; m_resp = 1'b0; m_gnt = 0; m_rr = 0; m_err = 1'b0;
            m_addr = '0; m_type = ACC_READ; m_priv = PRIV_M;
        end else if (m_busy) begin
            if (!csr_update) begin
                m_err  = pmp_deny(m_addr, m_type, m_priv, tb_cfg);
                m_resp = 1'b1;
                m_busy = 1'b0;
            end
        end else begin
            m_resp = 1'b0;
            g = first_valid(req_valid, m_rr);
            if (g >= 0) begin
                m_gnt  = g;
                m_addr = req_addr[g[1:0]];
                m_type = req_type[g[1:0]];
                m_priv = req_priv[g[1:0]];
                m_rr   = (g + 1) % N;
                m_busy = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b1; req_valid = '0; csr_update = 1'b0; tb_cfg = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst_i = 1'b1; req_valid = '1; csr_update = 1'b1;
        #4;
        n_cmp++; if (req_ready_o !== 3'b000) begin n_err++; $display("FAIL reset_ready_comb: got %b want 000", req_ready_o); end
        tick();
        #4;
        n_cmp++; if (req_ready_o !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 3'b000 || rsp_err_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got %b/%b want 000/0", rsp_valid_o, rsp_err_o); end
        n_cmp++; if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== ACC_READ || pmp_priv_o !== PRIV_M) begin
            n_err++; $display("FAIL reset_pmp: got %h/%b/%b want 0/10/11", pmp_req_addr_o, pmp_req_type_o, pmp_priv_o); end
        tick();
        rst_i = 1'b0; req_valid = '0; csr_update = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b010; req_addr[1] = 34'h0_8000_1000; req_type[1] = ACC_READ; req_priv[1] = PRIV_U;
        #4;
        n_cmp++; if (req_ready_o !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", req_ready_o); end
        tick();
        req_valid = '0;
        #4;
        n_cmp++; if (pmp_req_addr_o !== 34'h0_8000_1000) begin n_err++; $display("FAIL single_addr: got %h want 080001000", pmp_req_addr_o); end
        n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL single_early_rsp: got %b want 000", rsp_valid_o); end
        tick();
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b010 || rsp_err_o !== 1'b1) begin n_err++; $display("FAIL single_rsp: got %b/%b want 010/1", rsp_valid_o, rsp_err_o); end
    endtask

    task automatic test_round_robin();
        int gnt_q[$];
        int gnt_cyc[$];
        int rsp_q[$];
        do_reset();
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 34'({$urandom(), $urandom()}); req_type[i] = ACC_EXEC; req_priv[i] = PRIV_S;
        end
        for (int c = 0; c < 12; c++) begin
            #4;
            if (|req_ready_o) begin gnt_q.push_back(oh_idx(req_ready_o)); gnt_cyc.push_back(c); end
            if (|rsp_valid_o) rsp_q.push_back(oh_idx(rsp_valid_o));
            if (c < 11) tick();
        end
        n_cmp++; if (gnt_q.size() != 6) begin n_err++; $display("FAIL rr_grant_count: got %0d want 6", gnt_q.size()); end
        for (int i = 0; i < gnt_q.size() && i < 6; i++) begin
            n_cmp++; if (gnt_q[i] != i % N || gnt_cyc[i] != 2 * i) begin
                n_err++; $display("FAIL rr_grant_%0d: got req %0d at cycle %0d want req %0d at cycle %0d", i, gnt_q[i], gnt_cyc[i], i % N, 2 * i); end
        end
        n_cmp++; if (rsp_q.size() != 5) begin n_err++; $display("FAIL rr_rsp_count: got %0d want 5", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < 5; i++) begin
            n_cmp++; if (rsp_q[i] != i % N) begin n_err++; $display("FAIL rr_rsp_%0d: got %0d want %0d", i, rsp_q[i], i % N); end
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 3'b001;
        #4;
        n_cmp++; if (req_ready_o !== 3'b001) begin n_err++; $display("FAIL b2b_ready0: got %b want 001", req_ready_o); end
        tick();
        req_valid = 3'b100;
        #4;
        n_cmp++; if (req_ready_o !== 3'b000) begin n_err++; $display("FAIL b2b_ready_check: got %b want 000", req_ready_o); end
        tick();
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b001 || req_ready_o !== 3'b100) begin
            n_err++; $display("FAIL b2b_resp0: got rsp %b ready %b want 001/100", rsp_valid_o, req_ready_o); end
        tick();
        req_valid = '0;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL b2b_gap: got %b want 000", rsp_valid_o); end
        tick();
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b100) begin n_err++; $display("FAIL b2b_resp2: got %b want 100", rsp_valid_o); end
    endtask

    task automatic test_csr_update();
        do_reset();
        req_valid = 3'b001; req_addr[0] = 34'h0_0000_1000; req_type[0] = ACC_READ; req_priv[0] = PRIV_S;
        tick();
        req_valid = '0; csr_update = 1'b1; tb_cfg = 1'b1;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL csr_rsp_c1: got %b want 000", rsp_valid_o); end
        tick();
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000 || pmp_req_addr_o !== 34'h0_0000_1000) begin
            n_err++; $display("FAIL csr_c2: got rsp %b addr %h want 000/000001000", rsp_valid_o, pmp_req_addr_o); end
        tick();
        csr_update = 1'b0;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL csr_rsp_c3: got %b want 000", rsp_valid_o); end
        tick();
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b001 || rsp_err_o !== 1'b1) begin n_err++; $display("FAIL csr_rsp: got %b/%b want 001/1", rsp_valid_o, rsp_err_o); end
        tick();
        tb_cfg = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 3'b010; req_addr[1] = 34'h2_1234_5678; req_type[1] = ACC_WRITE; req_priv[1] = PRIV_U;
        tick();
        req_valid = '0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000 || rsp_err_o !== 1'b0) begin n_err++; $display("FAIL rstmid_rsp: got %b/%b want 000/0", rsp_valid_o, rsp_err_o); end
        n_cmp++; if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== ACC_READ || pmp_priv_o !== PRIV_M) begin
            n_err++; $display("FAIL rstmid_pmp: got %h/%b/%b want 0/10/11", pmp_req_addr_o, pmp_req_type_o, pmp_priv_o); end
        tick();
        req_valid = 3'b110;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL rstmid_rsp2: got %b want 000", rsp_valid_o); end
        n_cmp++; if (req_ready_o !== 3'b010) begin n_err++; $display("FAIL rstmid_grant: got %b want 010", req_ready_o); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req_valid = 3'b001;
        tick();
        req_valid = 3'b010;
        #4;
        n_cmp++; if (req_ready_o !== 3'b000) begin n_err++; $display("FAIL wd_ready_check: got %b want 000", req_ready_o); end
        tick();
        req_valid = '0;
        #4;
        n_cmp++; if (rsp_valid_o !== 3'b001 || req_ready_o !== 3'b000) begin
            n_err++; $display("FAIL wd_resp: got rsp %b ready %b want 001/000", rsp_valid_o, req_ready_o); end
        for (int c = 0; c < 3; c++) begin
            tick();
            #4;
            n_cmp++; if (rsp_valid_o !== 3'b000) begin n_err++; $display("FAIL wd_spurious_%0d: got %b want 000", c, rsp_valid_o); end
        end
        tick();
        req_valid = 3'b011;
        #4;
        n_cmp++; if (req_ready_o !== 3'b010) begin n_err++; $display("FAIL wd_rr: got %b want 010", req_ready_o); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        int           r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_i      = ($urandom_range(0, 39) == 0);
            req_valid  = N'($urandom());
            csr_update = ($urandom_range(0, 3) == 0);
            if (csr_update && $urandom_range(0, 1) == 1) tb_cfg = ~tb_cfg;
            for (int i = 0; i < N; i++) begin
                req_addr[i] = 34'({$urandom(), $urandom()});
                if ($urandom_range(0, 1) == 1) req_addr[i][31:28] = 4'h8;
                r = $urandom_range(0, 2);
                req_type[i] = r[1:0];
                r = $urandom_range(0, 2);
                req_priv[i] = (r == 2) ? PRIV_M : r[1:0];
            end
            #4;
            exp_ready = (rst_i || m_busy) ? '0 : idx_oh(first_valid(req_valid, m_rr));
            exp_rsp   = m_resp ? idx_oh(m_gnt) : '0;
            n_cmp++; if (req_ready_o !== exp_ready) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready_o, exp_ready); end
            n_cmp++; if (rsp_valid_o !== exp_rsp || rsp_err_o !== (m_resp & m_err)) begin
                n_err++; $display("FAIL rand_rsp c%0d: got %b/%b want %b/%b", c, rsp_valid_o, rsp_err_o, exp_rsp, m_resp & m_err); end
            n_cmp++; if (pmp_req_addr_o !== m_addr || pmp_req_type_o !== m_type || pmp_priv_o !== m_priv) begin
                n_err++; $display("FAIL rand_pmp c%0d: got %h/%b/%b want %h/%b/%b", c, pmp_req_addr_o, pmp_req_type_o, pmp_priv_o, m_addr, m_type, m_priv); end
            tick();
        end
        rst_i = 1'b0; req_valid = '0; csr_update = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_csr_update();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
